// File: rtl/enemy_fire_ctrl_pkg.sv
// Shared game definitions: direction codes, tank geometry, fire-controller states.
// Also holds a small unsigned distance helper used for alignment and aiming.
package enemy_fire_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int unsigned TANK_SIZE            = 30;
    localparam int unsigned RELOAD_TICKS_DEFAULT = 60;

    typedef enum logic [1:0] {
        ST_DEAD   = 2'd0,
        ST_RELOAD = 2'd1,
        ST_ARMED  = 2'd2,
        ST_FIRE   = 2'd3
    } fire_state_t;

    // Compare-then-subtract keeps screen distances unsigned.
    function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed and advance enable.
// OUT_W selects how many low-order bits are exposed to the user.
module lfsr16 #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk_f,
    input  logic             rst,
    input  logic             advance,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_reg;
    logic        feedback;

    assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk_f) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else if (advance) begin
            lfsr_reg <= {lfsr_reg[14:0], feedback};
        end
    end

    assign value = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/enemy_fire_ctrl.sv
// Per-enemy-tank fire controller: reload timing, fire decision, launch confirmation
// against the bullet stage, and aim direction toward the player.
module enemy_fire_ctrl
    import enemy_fire_ctrl_pkg::*;
#(
    parameter int unsigned RELOAD_TICKS = RELOAD_TICKS_DEFAULT,
    parameter logic [7:0]  FIRE_PROB    = 8'd64,
    parameter logic [9:0]  ALIGN_TOL    = 10'd8,
    parameter int unsigned FIRE_TIMEOUT = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk_f,
    input  logic       rst,
    input  logic       tank_alive,
    input  logic       player_alive,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       bullet_exit,
    input  logic       bullet_exit_reg,
    output logic       shoot,
    output logic [5:0] bullet_counter,
    output logic [1:0] aim_dir,
    output logic [7:0] shots_fired
);

    localparam logic [5:0] RELOAD_CNT   = 6'(RELOAD_TICKS);
    localparam logic [3:0] TIMEOUT_LAST = 4'(FIRE_TIMEOUT - 1);
    localparam logic [9:0] CENTER_OFF   = 10'(TANK_SIZE / 2);

    fire_state_t state_reg, state_next;
    logic        shoot_reg, shoot_next;
    logic [5:0]  counter_reg, counter_next;
    logic [7:0]  shots_reg, shots_next;
    logic [3:0]  timeout_reg, timeout_next;
    logic [1:0]  aim_reg, aim_next;

    logic        lfsr_advance;
    logic [7:0]  rand_byte;

    logic [9:0]  tank_cx, tank_cy, player_cx, player_cy;
    logic [9:0]  dist_x, dist_y;
    logic        aligned, fire_cond, launch_seen;
    logic [1:0]  aim_calc;

    // The draw only moves while armed, so a dead tank keeps its sequence position.
    assign lfsr_advance = (state_reg == ST_ARMED) && tank_alive;

    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (8)
    ) u_lfsr (
        .clk_f   (clk_f),
        .rst     (rst),
        .advance (lfsr_advance),
        .value   (rand_byte)
    );

    assign tank_cx   = tank_x + CENTER_OFF;
    assign tank_cy   = tank_y + CENTER_OFF;
    assign player_cx = player_x + CENTER_OFF;
    assign player_cy = player_y + CENTER_OFF;
    assign dist_x    = abs_diff10(tank_cx, player_cx);
    assign dist_y    = abs_diff10(tank_cy, player_cy);

    assign aligned     = (dist_x < ALIGN_TOL) || (dist_y < ALIGN_TOL);
    assign fire_cond   = player_alive && (aligned || (rand_byte < FIRE_PROB));
    assign launch_seen = bullet_exit && !bullet_exit_reg;

    always_comb begin
        aim_calc = DIR_UP;
        if (dist_x >= dist_y) begin
            aim_calc = (player_x > tank_x) ? DIR_RIGHT : DIR_LEFT;
        end else begin
            aim_calc = (player_y > tank_y) ? DIR_DOWN : DIR_UP;
        end
    end

    always_ff @(posedge clk_f) begin
        if (rst) begin
            state_reg   <= ST_RELOAD;
            shoot_reg   <= 1'b0;
            counter_reg <= 6'd0;
            shots_reg   <= 8'd0;
            timeout_reg <= 4'd0;
            aim_reg     <= DIR_UP;
        end else begin
            state_reg   <= state_next;
            shoot_reg   <= shoot_next;
            counter_reg <= counter_next;
            shots_reg   <= shots_next;
            timeout_reg <= timeout_next;
            aim_reg     <= aim_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shoot_next   = shoot_reg;
        counter_next = counter_reg;
        shots_next   = shots_reg;
        timeout_next = timeout_reg;
        aim_next     = aim_reg;

        if ((state_reg != ST_DEAD) && player_alive) begin
            aim_next = aim_calc;
        end

        if (!tank_alive) begin
            state_next   = ST_DEAD;
            shoot_next   = 1'b0;
            counter_next = 6'd0;
            timeout_next = 4'd0;
        end else begin
            case (state_reg)
                ST_DEAD: begin
                    state_next   = ST_RELOAD;
                    shoot_next   = 1'b0;
                    counter_next = 6'd0;
                end
                ST_RELOAD: begin
                    shoot_next = 1'b0;
                    // Reload time only accrues once the previous bullet has left play.
                    if (!bullet_exit) begin
                        if (counter_reg >= RELOAD_CNT - 6'd1) begin
                            counter_next = RELOAD_CNT;
                            state_next   = ST_ARMED;
                        end else begin
                            counter_next = counter_reg + 6'd1;
                        end
                    end
                end
                ST_ARMED: begin
                    shoot_next   = 1'b0;
                    counter_next = RELOAD_CNT;
                    if (fire_cond) begin
                        state_next   = ST_FIRE;
                        shoot_next   = 1'b1;
                        timeout_next = 4'd0;
                    end
                end
                ST_FIRE: begin
                    shoot_next   = 1'b1;
                    counter_next = RELOAD_CNT;
                    // A confirmed launch wins over a timeout landing on the same tick.
                    if (launch_seen) begin
                        state_next   = ST_RELOAD;
                        shoot_next   = 1'b0;
                        counter_next = 6'd0;
                        shots_next   = shots_reg + 8'd1;
                    end else if (timeout_reg == TIMEOUT_LAST) begin
                        state_next = ST_ARMED;
                        shoot_next = 1'b0;
                    end else begin
                        timeout_next = timeout_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = ST_RELOAD;
                    shoot_next = 1'b0;
                end
            endcase
        end
    end

    assign shoot          = shoot_reg;
    assign bullet_counter = counter_reg;
    assign aim_dir        = aim_reg;
    assign shots_fired    = shots_reg;

endmodule

// File: tb/tb_enemy_fire_ctrl.sv
// Directed bench for enemy_fire_ctrl with a scoreboard queue and a stub bullet stage.
// Random firing is disabled (FIRE_PROB=0) so every shot comes from alignment.
module tb_enemy_fire_ctrl;

    logic       clk_f = 1'b0;
    logic       rst;
    logic       tank_alive;
    logic       player_alive;
    logic [9:0] tank_x, tank_y, player_x, player_y;
    logic       bullet_exit;
    logic       bullet_exit_reg;
    logic       shoot;
    logic [5:0] bullet_counter;
    logic [1:0] aim_dir;
    logic [7:0] shots_fired;

    logic       stub_en;
    logic       stub_rst;
    logic       stub_exit;
    logic       force_exit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       shoot;
        logic [5:0] cnt;
        logic [7:0] shots;
        logic [1:0] aim;
        bit         chk_aim;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk_f = ~clk_f;

    enemy_fire_ctrl #(
        .RELOAD_TICKS (60),
        .FIRE_PROB    (8'd0),
        .ALIGN_TOL    (10'd8),
        .FIRE_TIMEOUT (8),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk_f           (clk_f),
        .rst             (rst),
        .tank_alive      (tank_alive),
        .player_alive    (player_alive),
        .tank_x          (tank_x),
        .tank_y          (tank_y),
        .player_x        (player_x),
        .player_y        (player_y),
        .bullet_exit     (bullet_exit),
        .bullet_exit_reg (bullet_exit_reg),
        .shoot           (shoot),
        .bullet_counter  (bullet_counter),
        .aim_dir         (aim_dir),
        .shots_fired     (shots_fired)
    );

    // Stub bullet stage: launches the tick after it sees shoot, stays in flight until cleared.
    always @(posedge clk_f) begin
        if (stub_rst) stub_exit <= 1'b0;
        else if (stub_en && shoot) stub_exit <= 1'b1;
    end
    assign bullet_exit = stub_exit | force_exit;
    always @(posedge clk_f) bullet_exit_reg <= bullet_exit;

    task automatic chk(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, want);
        end
    endtask

    // Monitor: compares every pending expectation against the outputs mid-cycle.
    always @(negedge clk_f) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "shoot", {7'd0, shoot}, {7'd0, e.shoot});
            chk(e.name, "bullet_counter", {2'd0, bullet_counter}, {2'd0, e.cnt});
            chk(e.name, "shots_fired", shots_fired, e.shots);
            if (e.chk_aim) chk(e.name, "aim_dir", {6'd0, aim_dir}, {6'd0, e.aim});
            $display("t=%0t %s: shoot=%0d cnt=%0d shots=%0d aim=%0d",
                     $time, e.name, shoot, bullet_counter, shots_fired, aim_dir);
        end
    end

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic expect_out(input string name, input logic sh, input int cnt, input int shots);
        exp_t e;
        e.name = name; e.shoot = sh; e.cnt = 6'(cnt); e.shots = 8'(shots);
        e.aim = 2'b00; e.chk_aim = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic expect_aim(input string name, input logic sh, input int cnt,
                              input int shots, input logic [1:0] aim);
        exp_t e;
        e.name = name; e.shoot = sh; e.cnt = 6'(cnt); e.shots = 8'(shots);
        e.aim = aim; e.chk_aim = 1'b1;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; tank_alive = 1'b1; player_alive = 1'b1;
        tank_x = 10'd100; tank_y = 10'd100; player_x = 10'd500; player_y = 10'd500;
        force_exit = 1'b0; stub_en = 1'b0; stub_rst = 1'b1;

        tick(); tick();
        expect_aim("reset", 1'b0, 0, 0, 2'b00);
        rst = 1'b0; stub_rst = 1'b0;

        // Full reload with the player far away: 1..60 then armed.
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) expect_aim("reload_first", 1'b0, 1, 0, 2'b11);
            else        expect_out("reload_count", 1'b0, k, 0);
        end
        tick(); expect_out("armed_idle", 1'b0, 60, 0);
        tick(); expect_out("armed_idle", 1'b0, 60, 0);

        // Aligned in x: fire, stub launches, confirm after two ticks.
        stub_en = 1'b1; player_x = 10'd104;
        tick(); expect_out("fire_assert", 1'b1, 60, 0);
        tick(); expect_out("fire_hold", 1'b1, 60, 0);
        tick(); expect_aim("launch", 1'b0, 0, 1, 2'b01);
        stub_en = 1'b0;
        tick(); expect_out("reload_inflight", 1'b0, 0, 1);
        stub_rst = 1'b1; player_x = 10'd500;
        tick(); expect_out("reload_inflight", 1'b0, 0, 1);
        stub_rst = 1'b0;

        // Reload count pauses while a bullet is in flight.
        for (int k = 1; k <= 20; k++) begin
            tick(); expect_out("reload_count", 1'b0, k, 1);
        end
        force_exit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("reload_exit_hold", 1'b0, 20, 1);
        end
        force_exit = 1'b0;
        tick(); expect_out("reload_resume", 1'b0, 21, 1);
        for (int k = 22; k <= 30; k++) begin
            tick(); expect_out("reload_count", 1'b0, k, 1);
        end

        // Tank killed mid-reload, then revived.
        tank_alive = 1'b0;
        tick(); expect_out("kill", 1'b0, 0, 1);
        tick(); expect_out("dead", 1'b0, 0, 1);
        tank_alive = 1'b1;
        tick(); expect_out("revive", 1'b0, 0, 1);
        tick(); expect_out("restart", 1'b0, 1, 1);
        for (int k = 2; k <= 60; k++) begin
            tick(); expect_out("reload_count", 1'b0, k, 1);
        end

        // Fire with no launch: shoot held 8 ticks, then back to armed.
        player_x = 10'd104;
        tick(); expect_out("to_fire", 1'b1, 60, 1);
        for (int i = 1; i <= 7; i++) begin
            tick(); expect_out("to_hold", 1'b1, 60, 1);
        end
        tick(); expect_out("timeout", 1'b0, 60, 1);
        tick(); expect_out("refire", 1'b1, 60, 1);
        player_x = 10'd500;
        for (int i = 1; i <= 7; i++) begin
            tick(); expect_out("refire_hold", 1'b1, 60, 1);
        end
        tick(); expect_out("timeout2", 1'b0, 60, 1);
        tick(); expect_out("armed_far", 1'b0, 60, 1);

        // Aim direction.
        tank_x = 10'd100; tank_y = 10'd120; player_x = 10'd400; player_y = 10'd100;
        tick(); expect_aim("aim_right", 1'b0, 60, 1, 2'b11);
        player_x = 10'd110; player_y = 10'd400;
        tick(); expect_aim("aim_down", 1'b0, 60, 1, 2'b01);

        // Player gone: aligned but no fire, aim holds.
        player_alive = 1'b0; player_x = 10'd104; player_y = 10'd120;
        tick(); expect_aim("player_dead", 1'b0, 60, 1, 2'b01);
        tick(); expect_aim("player_dead", 1'b0, 60, 1, 2'b01);

        // Reset while firing.
        player_alive = 1'b1;
        tick(); expect_aim("fire_before_rst", 1'b1, 60, 1, 2'b11);
        rst = 1'b1;
        tick(); expect_aim("rst_in_fire", 1'b0, 0, 0, 2'b00);
        rst = 1'b0;

        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_fire_ctrl.md
# enemy_fire_ctrl

Per-enemy-tank fire controller that sits directly upstream of that tank's enemy bullet stage. It runs the reload timer and decides when to fire, using player alignment plus a pseudo-random draw. It drives the bullet stage's `shoot` and `bullet_counter` inputs and watches that stage's `bullet_exit`/`bullet_exit_reg` to confirm each launch. It also publishes an aim direction that the tank movement logic uses to turn toward the player.

## Interface
- `RELOAD_TICKS`, 60: ticks from bullet gone to armed. Also the value the bullet stage compares `bullet_counter` against.
- `FIRE_PROB`, 8'd64: a random draw fires when `lfsr[7:0] < FIRE_PROB`.
- `ALIGN_TOL`, 10'd8: centre-to-centre tolerance, in pixels, for counting as aligned.
- `FIRE_TIMEOUT`, 8: ticks `shoot` is held without a launch before the controller gives up.
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR. Must be non-zero and distinct per instance.

Ports:
- `clk_f` in 1: game tick clock, the same clock as the bullet stage.
- `rst` in 1: reset, synchronous and active-high.
- `tank_alive` in 1: this enemy tank exists.
- `player_alive` in 1: the player tank exists.
- `tank_x`, `tank_y` in 10 each: this tank's top-left position. The tank is 30x30.
- `player_x`, `player_y` in 10 each: the player's top-left position. The player is 30x30.
- `bullet_exit` in 1: this tank's bullet is in flight (from the bullet stage).
- `bullet_exit_reg` in 1: `bullet_exit` delayed by one tick (from the bullet stage).
- `shoot` out 1: fire request to the bullet stage.
- `bullet_counter` out 6: reload count. It equals `RELOAD_TICKS` exactly when the controller is armed or firing.
- `aim_dir` out 2: direction toward the player. 00 up, 01 down, 10 left, 11 right.
- `shots_fired` out 8: count of confirmed launches; wraps.

## Operation
- States are DEAD, RELOAD, ARMED and FIRE. Reset puts the state in RELOAD.
- Reset values: `shoot`=0, `bullet_counter`=0, `aim_dir`=00, `shots_fired`=0, `lfsr`=`LFSR_SEED`.
- The kill rule has priority over every other transition. When `tank_alive`=0 in any state:
  - next state is DEAD;
  - `shoot` is 0 and `bullet_counter` is 0;
  - the LFSR is frozen.
- DEAD goes to RELOAD on the first tick with `tank_alive`=1.
- RELOAD:
  - when `bullet_exit`=1, the counter holds, because reload starts only once the previous bullet is gone;
  - otherwise the counter increments by 1;
  - on the tick the counter is written with `RELOAD_TICKS`, the next state is ARMED. The counter saturates and never exceeds `RELOAD_TICKS`.
- ARMED:
  - the LFSR advances once per tick. It is a 16-bit Fibonacci LFSR with taps 16,14,13,11;
  - the fire condition is `player_alive` && (`aligned` || `lfsr[7:0]` < `FIRE_PROB`);
  - `aligned` is true when |(`tank_x`+15)−(`player_x`+15)| < `ALIGN_TOL` or |(`tank_y`+15)−(`player_y`+15)| < `ALIGN_TOL`;
  - all differences use unsigned compare-then-subtract in 10 bits, so there is no signed arithmetic;
  - when the fire condition holds, next state is FIRE and `shoot` becomes 1.
- FIRE:
  - `shoot` stays at 1 and `bullet_counter` stays at `RELOAD_TICKS`;
  - a launch is confirmed by `bullet_exit`=1 && `bullet_exit_reg`=0. On that tick: `shoot` goes to 0, `bullet_counter` goes to 0, `shots_fired` increments, and next state is RELOAD;
  - if no launch is seen within `FIRE_TIMEOUT` ticks, `shoot` goes to 0 and next state is ARMED with the counter kept at `RELOAD_TICKS`. This covers the bullet stage blocking the shot, for example when its chain-enable input is low.
- `aim_dir` is recomputed every tick in every state except DEAD, where it holds:
  - if |dx| ≥ |dy|, the direction is horizontal: 11 when `player_x` > `tank_x`, else 10;
  - otherwise it is vertical: 01 when `player_y` > `tank_y`, else 00;
  - when `player_alive`=0, `aim_dir` holds.
- Simultaneous events:
  - a confirmed launch takes priority over the timeout on the same tick;
  - `rst` takes priority over everything.

## Timing
- All outputs are registered.
- From ARMED with the condition true at edge t: `shoot`=1 after edge t.
- The bullet stage sets `bullet_exit` at edge t+1.
- This block sees the launch at edge t+2, where `shoot` drops and the counter clears. Normal `shoot` pulse width is therefore 2 ticks.
- A full cycle from bullet gone to armed is `RELOAD_TICKS` ticks, counted while `bullet_exit`=0.
- The timeout counter is 4 bits. It clears on entry to FIRE, and the timeout fires when the count reaches `FIRE_TIMEOUT`−1.
- Reset asserted mid-FIRE: `shoot` is 0 on the next edge, with no launch counted.

## Structure
- The shared game package holds:
  - the direction encodings `DIR_UP`=00, `DIR_DOWN`=01, `DIR_LEFT`=10, `DIR_RIGHT`=11;
  - `TANK_SIZE`=30;
  - the fire-controller state enum;
  - the default `RELOAD_TICKS`.
- One sub-module, `lfsr16`, containing the seed and an advance enable. It is reused by the enemy movement logic.

## Test plan
- Reset, then `tank_alive`=1, `bullet_exit`=0, player far and `FIRE_PROB`=0: `bullet_counter` counts 1..60 and reaches 60 on tick 60; `shoot` stays 0.
- Armed, `tank_x`=100 and `player_x`=104: `shoot`=1 on the next tick. A stub bullet stage raises `bullet_exit` one tick later; `shoot` is 0 two ticks after asserting, `bullet_counter`=0 and `shots_fired`=1.
- Armed and firing with `bullet_exit` held at 0: `shoot` is high for 8 ticks, then 0; state returns to ARMED and `bullet_counter` stays at 60.
- `tank_alive` drops mid-RELOAD at count 30: the next tick shows counter 0, `shoot` 0. When `tank_alive` returns, counting restarts from 1.
- Player at (400,100), tank at (100,120): `aim_dir`=11. Player at (110,400): `aim_dir`=01.
- `bullet_exit`=1 during RELOAD at count 20: the counter holds at 20 until `bullet_exit`=0, then resumes at 21.
